// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receive path.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_CODE  = 8'hE0;
  localparam logic [7:0] PS2_BRK_CODE  = 8'hF0;
  localparam int         PS2_DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

endpackage

// File: rtl/ps2_edge_sync.sv
// Brings the raw PS/2 clock/data lines into the clk domain and produces a
// one-cycle strobe on each PS/2 clock falling edge, with data aligned to it.
module ps2_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset1,
  input  logic kb_clk1,
  input  logic kb_data1,
  output logic fall,
  output logic data
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;

  // Lines idle high, so the chain resets to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (reset1) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
      fall      <= 1'b0;
      data      <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], kb_clk1};
      data_sync <= {data_sync[SYNC_STAGES-2:0], kb_data1};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
      fall      <= clk_prev & ~clk_sync[SYNC_STAGES-1];
      data      <= data_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: frames 11-bit packets, folds E0/F0 prefixes into
// flags and queues scancodes in a FIFO. Define PS2_PARITY_CHECK_EN to reject odd-parity failures.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset1,
  input  logic       kb_clk1,
  input  logic       kb_data1,
  output logic [7:0] code_o,
  output logic       ext_o,
  output logic       brk_o,
  output logic       code_valid_o,
  input  logic       code_ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overflow_o,
  output logic [7:0] display_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic             fall;
  logic             rx_data;
  ps2_state_e       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             frame_err_d;
  logic             byte_stb_q, byte_stb_d;
  logic             byte_bad_q, byte_bad_d;
  logic             ext_pend, brk_pend;
  logic [AW:0]      wr_ptr, rd_ptr, wr_next, rd_next;
  ps2_entry_t       mem [FIFO_DEPTH];
  ps2_entry_t       new_entry, head_next;
  logic             push_req, push_ok, pop, full, valid_next;

  ps2_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset1   (reset1),
    .kb_clk1  (kb_clk1),
    .kb_data1 (kb_data1),
    .fall     (fall),
    .data     (rx_data)
  );

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_CHECK = 1'b1;
  logic par_err_q;
  always_ff @(posedge clk) begin
    if (reset1) par_err_q <= 1'b0;
    else        par_err_q <= byte_stb_d & byte_bad_d;
  end
  assign parity_err_o = par_err_q;
`else
  localparam bit PAR_CHECK = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  // Frame FSM; the watchdog only runs while a frame is in progress.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tmo_d       = tmo_q;
    frame_err_d = 1'b0;
    byte_stb_d  = 1'b0;
    byte_bad_d  = 1'b0;
    if (fall) begin
      tmo_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!rx_data) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {rx_data, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = rx_data;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!rx_data) begin
            frame_err_d = 1'b1;
          end else begin
            byte_stb_d = 1'b1;
            byte_bad_d = PAR_CHECK & ~(^{shift_q, par_q});
          end
        end
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d     = IDLE;
        tmo_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset1) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      frame_err_o <= 1'b0;
      byte_stb_q  <= 1'b0;
      byte_bad_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      frame_err_o <= frame_err_d;
      byte_stb_q  <= byte_stb_d;
      byte_bad_q  <= byte_bad_d;
    end
  end

  assign push_req  = byte_stb_q & ~byte_bad_q &
                     (shift_q != PS2_EXT_CODE) & (shift_q != PS2_BRK_CODE);
  assign pop       = code_valid_o & code_ready_i;
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok   = push_req & (~full | pop);
  assign wr_next   = wr_ptr + {{AW{1'b0}}, push_ok};
  assign rd_next   = rd_ptr + {{AW{1'b0}}, pop};
  assign valid_next = (wr_next != rd_next);
  assign new_entry = '{ext: ext_pend, brk: brk_pend, code: shift_q};
  // A push landing exactly at the next head slot is forwarded straight out.
  assign head_next = (push_ok && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) ?
                     new_entry : mem[rd_next[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (reset1) begin
      ext_pend     <= 1'b0;
      brk_pend     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      code_valid_o <= 1'b0;
      code_o       <= '0;
      ext_o        <= 1'b0;
      brk_o        <= 1'b0;
      overflow_o   <= 1'b0;
      display_o    <= '0;
    end else begin
      if (byte_stb_q) begin
        if (byte_bad_q) begin
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end else if (shift_q == PS2_EXT_CODE) begin
          ext_pend <= 1'b1;
        end else if (shift_q == PS2_BRK_CODE) begin
          brk_pend <= 1'b1;
        end else begin
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
          display_o <= shift_q;
          if (!push_ok) overflow_o <= 1'b1;
        end
      end
      wr_ptr       <= wr_next;
      rd_ptr       <= rd_next;
      code_valid_o <= valid_next;
      {ext_o, brk_o, code_o} <= valid_next ? head_next : '0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: framed PS/2 stimulus, a queue-based
// reference model, and a monitor that checks each accepted FIFO entry.
module tb_ps2_rx_fifo;

  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CYC = 200;
  localparam int HALF        = 20;

  logic       clk = 1'b0;
  logic       reset1;
  logic       kb_clk1;
  logic       kb_data1;
  logic [7:0] code_o;
  logic       ext_o;
  logic       brk_o;
  logic       code_valid_o;
  logic       code_ready_i;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       overflow_o;
  logic [7:0] display_o;

  int         checks = 0;
  int         failures = 0;
  logic [9:0] exp_q[$];
  bit         m_ext, m_brk, m_ovf;
  int         ready_mode = 0;
  int         frame_err_cnt = 0;
  int         parity_err_cnt = 0;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .reset1       (reset1),
    .kb_clk1      (kb_clk1),
    .kb_data1     (kb_data1),
    .code_o       (code_o),
    .ext_o        (ext_o),
    .brk_o        (brk_o),
    .code_valid_o (code_valid_o),
    .code_ready_i (code_ready_i),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .overflow_o   (overflow_o),
    .display_o    (display_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: what a complete, well-framed byte should do to the queue.
  function automatic void modelFrame(input logic [7:0] b, input bit par_ok);
    bit chk = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    chk = 1'b1;
`endif
    if (chk && !par_ok) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (ready_mode == 0 && exp_q.size() >= FIFO_DEPTH) m_ovf = 1'b1;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic        par;
    logic [10:0] bits;
    par  = ~(^b) ^ bad_par;
    bits = {~bad_stop, par, b, 1'b0};
    if (nbits == 11 && !bad_stop) modelFrame(b, !bad_par);
    for (int i = 0; i < nbits; i++) begin
      kb_data1 = bits[i];
      waitCycles(HALF);
      kb_clk1 = 1'b0;
      waitCycles(HALF);
      kb_clk1 = 1'b1;
    end
    kb_data1 = 1'b1;
    waitCycles(HALF);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    ready_mode = 2;
    while ((exp_q.size() != 0 || code_valid_o) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    code_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       code_ready_i = 1'b0;
        1:       code_ready_i = 1'($urandom_range(0, 1));
        default: code_ready_i = 1'b1;
      endcase
    end
  end

  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (reset1 === 1'b0) begin
        if (frame_err_o)  frame_err_cnt++;
        if (parity_err_o) parity_err_cnt++;
        if (code_valid_o && code_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_entry: got 0x%0h, expected no entry", {ext_o, brk_o, code_o});
          end else begin
            e = exp_q.pop_front();
            checkOutput("fifo_head", {22'b0, ext_o, brk_o, code_o}, {22'b0, e});
          end
        end
      end
    end
  end

  initial begin
    int fe;
    int pe;
    int exp_pe;
    logic [7:0] b;
    reset1   = 1'b1;
    kb_clk1  = 1'b1;
    kb_data1 = 1'b1;
    waitCycles(5);
    checkOutput("reset_outputs", {10'b0, code_o, ext_o, brk_o, code_valid_o, frame_err_o,
                                  parity_err_o, overflow_o, display_o}, 0);
    reset1 = 1'b0;
    waitCycles(5);

    $display("[TB] single make code");
    applyStimulus(8'h1C, 0, 0, 11);
    waitCycles(10);
    checkOutput("valid_after_1c", code_valid_o, 1);
    checkOutput("display_1c", display_o, 8'h1C);
    drain(200);

    $display("[TB] extended release");
    ready_mode = 1;
    applyStimulus(8'hE0, 0, 0, 11);
    applyStimulus(8'hF0, 0, 0, 11);
    applyStimulus(8'h75, 0, 0, 11);
    drain(200);

    $display("[TB] random frames");
    ready_mode = 1;
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 5))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: b = 8'($urandom);
      endcase
      applyStimulus(b, 0, 0, 11);
    end
    drain(200);

    $display("[TB] bad start bit");
    fe = frame_err_cnt;
    kb_data1 = 1'b1;
    waitCycles(HALF);
    kb_clk1 = 1'b0;
    waitCycles(HALF);
    kb_clk1 = 1'b1;
    waitCycles(HALF);
    checkOutput("start_err_pulse", frame_err_cnt - fe, 1);

    $display("[TB] bad stop bit");
    fe = frame_err_cnt;
    applyStimulus(8'h33, 0, 1, 11);
    checkOutput("stop_err_pulse", frame_err_cnt - fe, 1);

    $display("[TB] timeout");
    applyStimulus(8'hE0, 0, 0, 11);
    fe = frame_err_cnt;
    applyStimulus(8'h5A, 0, 0, 5);
    waitCycles(TIMEOUT_CYC + 10);
    checkOutput("timeout_pulse", frame_err_cnt - fe, 1);
    applyStimulus(8'h29, 0, 0, 11);
    drain(200);

    $display("[TB] parity");
    pe = parity_err_cnt;
    exp_pe = 0;
`ifdef PS2_PARITY_CHECK_EN
    exp_pe = 2;
`endif
    applyStimulus(8'h1C, 1, 0, 11);
    applyStimulus(8'hE0, 0, 0, 11);
    applyStimulus(8'h1C, 1, 0, 11);
    applyStimulus(8'h1C, 0, 0, 11);
    waitCycles(10);
    checkOutput("parity_err_pulses", parity_err_cnt - pe, exp_pe);
    drain(200);

    $display("[TB] overflow");
    ready_mode = 0;
    waitCycles(5);
    for (int i = 0; i < 5; i++) applyStimulus(8'h15 + 8'(i), 0, 0, 11);
    checkOutput("overflow_sticky", overflow_o, m_ovf);
    checkOutput("valid_full", code_valid_o, 1);
    drain(200);
    checkOutput("overflow_stays", overflow_o, 1);

    $display("[TB] reset mid-frame");
    ready_mode = 0;
    waitCycles(5);
    applyStimulus(8'h22, 0, 0, 11);
    applyStimulus(8'hE0, 0, 0, 11);
    applyStimulus(8'h44, 0, 0, 5);
    reset1 = 1'b1;
    waitCycles(3);
    checkOutput("midframe_reset_outputs", {10'b0, code_o, ext_o, brk_o, code_valid_o, frame_err_o,
                                           parity_err_o, overflow_o, display_o}, 0);
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_ovf = 1'b0;
    reset1 = 1'b0;
    waitCycles(5);
    applyStimulus(8'h1C, 0, 0, 11);
    waitCycles(10);
    checkOutput("display_after_reset", display_o, 8'h1C);
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 keyboard receiver that replaces the fixed edge-detect plus shift-register pair in the keyboard path. It synchronises `kb_clk1`/`kb_data1` into the system clock, frames 11-bit PS/2 packets, and checks start, stop and (optionally) parity. It folds `E0`/`F0` prefixes into flags and queues decoded scancodes in a FIFO with a valid/ready handshake. `display_o` keeps the last accepted scancode for the existing LED/7-seg consumer.

## Interface
- `FIFO_DEPTH`, default 8: FIFO entries; power of two, at least 2.
- `SYNC_STAGES`, default 2: flip-flop synchroniser depth on `kb_clk1`/`kb_data1`; at least 2.
- `TIMEOUT_CYC`, default 100000: `clk` cycles allowed between falling edges inside a frame.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `reset1`  in  1: synchronous, active-high reset.
- `kb_clk1`  in  1: raw PS/2 clock, asynchronous.
- `kb_data1`  in  1: raw PS/2 data, asynchronous.
- `code_o`  out  8: scancode at FIFO head.
- `ext_o`  out  1: head entry was preceded by `E0`.
- `brk_o`  out  1: head entry was preceded by `F0` (key release).
- `code_valid_o`  out  1: FIFO non-empty.
- `code_ready_i`  in  1: consumer accepts the head entry when `code_valid_o` is also high.
- `frame_err_o`  out  1: one-cycle pulse on bad start/stop bit or timeout.
- `parity_err_o`  out  1: one-cycle pulse on parity failure; tied 0 when `PS2_PARITY_CHECK_EN` is undefined.
- `overflow_o`  out  1: sticky; set when a code is dropped on a full FIFO.
- `display_o`  out  8: last scancode written to the FIFO.

## Operation
- Reset values: all outputs 0; FIFO empty; FSM in IDLE; prefix flags clear; timeout counter 0.
- Edge detect: a falling edge is registered sync output 1 followed by 0; it produces a one-cycle `fall` strobe.
- FSM states:
  - IDLE, on `fall`: data = 0 goes to DATA with bit count 0; data = 1 pulses `frame_err_o` and stays in IDLE.
  - DATA, on `fall`: shift the data bit in LSB first; after the 8th bit go to PARITY.
  - PARITY, on `fall`: capture the bit, go to STOP.
  - STOP, on `fall`: data = 0 pulses `frame_err_o`. Otherwise the byte is evaluated and the FSM returns to IDLE.
- Timeout:
  - The counter resets on every `fall` and counts while the FSM is outside IDLE.
  - Reaching `TIMEOUT_CYC` aborts the frame: go to IDLE, pulse `frame_err_o`, keep prefix flags.
- Decode of an accepted byte:
  - `E0`: set `ext_pend`; no push.
  - `F0`: set `brk_pend`; no push.
  - Any other byte: push `{ext_pend, brk_pend, byte}` (10 bits), clear both flags, load `display_o` with `byte`.
- FIFO:
  - Pop happens when `code_valid_o` and `code_ready_i` are both high.
  - Push on full with no pop in the same cycle: drop the entry and set `overflow_o`.
  - Push on full with a pop in the same cycle: both occur; no overflow.
  - Pointers carry one extra wrap bit to tell full from empty.
- Reset mid-frame discards the partial frame, the prefixes and the FIFO contents.

## Timing
- `fall` asserts `SYNC_STAGES`+1 cycles after the `kb_clk1` falling edge.
- FIFO write occurs on the cycle after the stop-bit `fall`; `code_valid_o` rises the following cycle.
- `code_o`/`ext_o`/`brk_o` are registered from the head entry and are stable while `code_valid_o` is high and no pop occurs.
- Pop takes effect on the accepting edge; the next entry is presented in the following cycle.
- Error pulses are exactly one cycle wide, issued the cycle after the offending `fall` or the timeout.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: a byte passes only if data plus parity has an odd number of 1s. A failing byte pulses `parity_err_o`, is not decoded, and clears the prefix flags.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is captured and ignored, and `parity_err_o` is a constant 0.

## Structure
- Package `ps2_pkg`:
  - Constants `PS2_EXT_CODE = 8'hE0`, `PS2_BRK_CODE = 8'hF0`, `PS2_DATA_BITS = 8`.
  - FSM state enum `{IDLE, DATA, PARITY, STOP}`.
  - FIFO entry typedef (ext, brk, code).
- Sub-module `ps2_edge_sync`: a synchroniser for both lines plus falling-edge strobe generation, parametrised by `SYNC_STAGES`.

## Test plan
- Single make code: frame 0, `0x1C` sent LSB first, parity 0, stop 1 -> one entry with `code_o = 0x1C`, `ext_o = 0`, `brk_o = 0`, and `display_o = 0x1C`.
- Extended release: `E0`, `F0`, `75` -> exactly one entry with `code_o = 0x75`, `ext_o = 1`, `brk_o = 1`.
- Parity: `0x1C` sent with parity 1 -> with the macro defined, no entry and one `parity_err_o` pulse; with it undefined, entry `0x1C` is pushed.
- Timeout: `kb_clk1` held high after 4 data bits for `TIMEOUT_CYC` + 10 cycles -> one `frame_err_o` pulse, FSM back in IDLE, and a following `0x29` frame is received correctly.
- Overflow: `FIFO_DEPTH` = 4 and `code_ready_i` = 0, send 5 codes `0x15`..`0x19` -> `overflow_o = 1`, four entries drain in order `0x15`..`0x18`.
- Reset mid-frame: assert `reset1` after 5 bits -> all outputs 0 and FIFO empty; the next full frame is received correctly.
